lock_session_ctrl: RTL and testbench

Sequences one code-entry session of the keypad lock: accepts validated key events from the keypad scanner and gates digit entry. It issues a submit strobe to the code comparator and takes back its verdict. It also counts wrong attempts and enforces a timed lockout. It sits between the keypad scanner and the decider/comparator, and its count/remaining-time outputs feed the segment display.

---
 rtl/lock_session_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_lock_session_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_session_ctrl.sv
// Code-entry session sequencer for the keypad lock: gates digit entry, issues
// submit/clear strobes to the comparator, counts wrong attempts and runs the lockout.
module lock_session_ctrl #(
    parameter int TICK_DIV        = 50000000,
    parameter int DIGITS          = 4,
    parameter int MAX_WRONG       = 3,
    parameter int ENTRY_TIMEOUT_S = 10,
    parameter int OPEN_S          = 5,
    parameter int LOCKOUT_S       = 30,
    parameter int VERDICT_WAIT    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       verdict_valid,
    input  logic       verdict_ok,
    output logic       entry_en,
    output logic [2:0] digit_count,
    output logic       submit,
    output logic       clear,
    output logic       open,
    output logic       lockout,
    output logic       alarm,
    output logic [3:0] wrong_count,
    output logic [7:0] lock_remain
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (VERDICT_WAIT > 1) ? $clog2(VERDICT_WAIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_WAIT_VERDICT,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [7:0]      sec_cnt, sec_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic [2:0]      digit_nxt;
    logic [3:0]      wrong_nxt;
    logic [7:0]      remain_nxt;
    logic            submit_nxt;
    logic            clear_nxt;
    logic            restart;
    logic            wrong_attempt;
    logic            tick;
    logic            is_digit;
    logic            is_clear;
    logic            is_enter;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == 4'hE);
    assign is_enter = key_valid && (key_code == 4'hF);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            sec_cnt     <= '0;
            wait_cnt    <= '0;
            digit_count <= '0;
            wrong_count <= '0;
            lock_remain <= '0;
            submit      <= 1'b0;
            clear       <= 1'b0;
            open        <= 1'b0;
            lockout     <= 1'b0;
            alarm       <= 1'b0;
            entry_en    <= 1'b1;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            sec_cnt     <= sec_nxt;
            wait_cnt    <= wait_nxt;
            digit_count <= digit_nxt;
            wrong_count <= wrong_nxt;
            lock_remain <= remain_nxt;
            submit      <= submit_nxt;
            clear       <= clear_nxt;
            open        <= (state_nxt == ST_OPEN);
            lockout     <= (state_nxt == ST_LOCKOUT);
            alarm       <= (state_nxt == ST_LOCKOUT);
            entry_en    <= (state_nxt == ST_IDLE) || (state_nxt == ST_ENTRY);
        end
    end

    always_comb begin
        state_nxt     = state;
        presc_nxt     = tick ? '0 : presc + PW'(1);
        sec_nxt       = tick ? sec_cnt + 8'd1 : sec_cnt;
        wait_nxt      = wait_cnt + WW'(1);
        digit_nxt     = digit_count;
        wrong_nxt     = wrong_count;
        remain_nxt    = lock_remain;
        submit_nxt    = 1'b0;
        clear_nxt     = 1'b0;
        restart       = 1'b0;
        wrong_attempt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (is_digit) begin
                    state_nxt = ST_ENTRY;
                    digit_nxt = 3'd1;
                end
            end

            ST_ENTRY: begin
                // A key wins over a timeout tick landing in the same cycle.
                if (is_digit) begin
                    restart = 1'b1;
                    if (digit_count < 3'(DIGITS)) begin
                        digit_nxt = digit_count + 3'd1;
                    end
                end else if (is_clear) begin
                    clear_nxt = 1'b1;
                    digit_nxt = 3'd0;
                    state_nxt = ST_IDLE;
                end else if (is_enter && (digit_count == 3'(DIGITS))) begin
                    submit_nxt = 1'b1;
                    state_nxt  = ST_WAIT_VERDICT;
                end else if (tick && (sec_cnt == 8'(ENTRY_TIMEOUT_S - 1))) begin
                    clear_nxt = 1'b1;
                    digit_nxt = 3'd0;
                    state_nxt = ST_IDLE;
                end
            end

            ST_WAIT_VERDICT: begin
                if (verdict_valid && verdict_ok) begin
                    state_nxt = ST_OPEN;
                    wrong_nxt = 4'd0;
                    digit_nxt = 3'd0;
                end else if (verdict_valid || (wait_cnt == WW'(VERDICT_WAIT - 1))) begin
                    wrong_attempt = 1'b1;
                end
                if (wrong_attempt) begin
                    clear_nxt = 1'b1;
                    digit_nxt = 3'd0;
                    wrong_nxt = wrong_count + 4'd1;
                    if (wrong_nxt == 4'(MAX_WRONG)) begin
                        state_nxt  = ST_LOCKOUT;
                        remain_nxt = 8'(LOCKOUT_S);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_OPEN: begin
                if (is_clear || (tick && (sec_cnt == 8'(OPEN_S - 1)))) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_LOCKOUT: begin
                // The <= guard keeps the countdown from wrapping below zero.
                if (tick) begin
                    if (lock_remain <= 8'd1) begin
                        remain_nxt = 8'd0;
                        wrong_nxt  = 4'd0;
                        state_nxt  = ST_IDLE;
                    end else begin
                        remain_nxt = lock_remain - 8'd1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Every state entry and every accepted ENTRY key restarts all timing.
        if ((state_nxt != state) || restart) begin
            presc_nxt = '0;
            sec_nxt   = '0;
            wait_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_lock_session_ctrl.sv
// Self-checking bench for lock_session_ctrl: vector table, directed corner
// sequences and random stimulus against a deadline-based reference model.
module tb_lock_session_ctrl;

    localparam int TICK_DIV        = 4;
    localparam int DIGITS          = 4;
    localparam int MAX_WRONG       = 3;
    localparam int ENTRY_TIMEOUT_S = 10;
    localparam int OPEN_S          = 5;
    localparam int LOCKOUT_S       = 30;
    localparam int VERDICT_WAIT    = 16;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_WAIT  = 2;
    localparam int M_OPEN  = 3;
    localparam int M_LOCK  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       verdict_valid = 1'b0;
    logic       verdict_ok = 1'b0;
    logic       entry_en;
    logic [2:0] digit_count;
    logic       submit;
    logic       clear;
    logic       open;
    logic       lockout;
    logic       alarm;
    logic [3:0] wrong_count;
    logic [7:0] lock_remain;

    always #5 clock = ~clock;

    lock_session_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DIGITS(DIGITS),
        .MAX_WRONG(MAX_WRONG),
        .ENTRY_TIMEOUT_S(ENTRY_TIMEOUT_S),
        .OPEN_S(OPEN_S),
        .LOCKOUT_S(LOCKOUT_S),
        .VERDICT_WAIT(VERDICT_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .verdict_valid(verdict_valid),
        .verdict_ok(verdict_ok),
        .entry_en(entry_en),
        .digit_count(digit_count),
        .submit(submit),
        .clear(clear),
        .open(open),
        .lockout(lockout),
        .alarm(alarm),
        .wrong_count(wrong_count),
        .lock_remain(lock_remain)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int now    = 0;

    // Reference model: timing kept as absolute deadlines from the cycle a phase began.
    int m_mode   = M_IDLE;
    int m_t0     = 0;
    int m_digits = 0;
    int m_wrong  = 0;
    bit m_submit = 1'b0;
    bit m_clear  = 1'b0;

    function void model_step(input bit rst, input bit kv, input logic [3:0] code,
                             input bit vv, input bit vok);
        bit dig;
        bit clr;
        bit ent;
        bit bad;
        dig      = kv && (code <= 4'd9);
        clr      = kv && (code == 4'hE);
        ent      = kv && (code == 4'hF);
        bad      = 1'b0;
        m_submit = 1'b0;
        m_clear  = 1'b0;
        if (rst) begin
            m_mode   = M_IDLE;
            m_digits = 0;
            m_wrong  = 0;
            m_t0     = now;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (dig) begin
                    m_mode = M_ENTRY; m_digits = 1; m_t0 = now;
                end
            end
            M_ENTRY: begin
                if (dig) begin
                    if (m_digits < DIGITS) m_digits = m_digits + 1;
                    m_t0 = now;
                end else if (clr) begin
                    m_clear = 1'b1; m_digits = 0; m_mode = M_IDLE;
                end else if (ent && m_digits == DIGITS) begin
                    m_submit = 1'b1; m_mode = M_WAIT; m_t0 = now;
                end else if (now - m_t0 == ENTRY_TIMEOUT_S * TICK_DIV) begin
                    m_clear = 1'b1; m_digits = 0; m_mode = M_IDLE;
                end
            end
            M_WAIT: begin
                if (vv && vok) begin
                    m_mode = M_OPEN; m_wrong = 0; m_digits = 0; m_t0 = now;
                end else if (vv || (now - m_t0 == VERDICT_WAIT)) begin
                    bad = 1'b1;
                end
                if (bad) begin
                    m_clear = 1'b1; m_digits = 0; m_wrong = m_wrong + 1;
                    if (m_wrong == MAX_WRONG) begin
                        m_mode = M_LOCK; m_t0 = now;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_OPEN: begin
                if (clr || (now - m_t0 == OPEN_S * TICK_DIV)) m_mode = M_IDLE;
            end
            M_LOCK: begin
                if (now - m_t0 == LOCKOUT_S * TICK_DIV) begin
                    m_mode = M_IDLE; m_wrong = 0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    function logic [20:0] model_vec();
        logic [7:0] rem;
        rem = (m_mode == M_LOCK) ? 8'(LOCKOUT_S - (now - m_t0) / TICK_DIV) : 8'd0;
        return {(m_mode == M_IDLE || m_mode == M_ENTRY), 3'(m_digits), m_submit, m_clear,
                (m_mode == M_OPEN), (m_mode == M_LOCK), (m_mode == M_LOCK), 4'(m_wrong), rem};
    endfunction

    task check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, now);
        end
    endtask

    task check_output();
        logic [20:0] got;
        logic [20:0] exp;
        got = {entry_en, digit_count, submit, clear, open, lockout, alarm, wrong_count, lock_remain};
        exp = model_vec();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL model cycle %0d: got %h, expected %h", now, got, exp);
        end
    endtask

    task apply_stimulus(input bit rst, input bit kv, input logic [3:0] code,
                        input bit vv, input bit vok);
        reset         = rst;
        key_valid     = kv;
        key_code      = code;
        verdict_valid = vv;
        verdict_ok    = vok;
        @(posedge clock);
        now++;
        model_step(rst, kv, code, vv, vok);
        #1;
        check_output();
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task press(input logic [3:0] c);
        apply_stimulus(1'b0, 1'b1, c, 1'b0, 1'b0);
    endtask

    task enter_code();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hF);
    endtask

    typedef struct {
        bit         kv;
        logic [3:0] code;
        bit         vv;
        bit         vok;
        int         e_digits;
        bit         e_en;
        bit         e_sub;
        bit         e_clr;
        bit         e_open;
        int         e_wrong;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cnt;
        int cyc;

        tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 4'hF, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 4'd3, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[11] = '{1'b1, 4'hE, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

        $display("[TB] reset state");
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check_val("rst_entry_en", int'(entry_en), 1);
        check_val("rst_digits", int'(digit_count), 0);
        check_val("rst_lockout", int'(lockout), 0);
        check_val("rst_remain", int'(lock_remain), 0);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(1'b0, tbl[i].kv, tbl[i].code, tbl[i].vv, tbl[i].vok);
            check_val($sformatf("tbl%0d_digits", i), int'(digit_count), tbl[i].e_digits);
            check_val($sformatf("tbl%0d_entry_en", i), int'(entry_en), int'(tbl[i].e_en));
            check_val($sformatf("tbl%0d_submit", i), int'(submit), int'(tbl[i].e_sub));
            check_val($sformatf("tbl%0d_clear", i), int'(clear), int'(tbl[i].e_clr));
            check_val($sformatf("tbl%0d_open", i), int'(open), int'(tbl[i].e_open));
            check_val($sformatf("tbl%0d_wrong", i), int'(wrong_count), tbl[i].e_wrong);
        end

        $display("[TB] correct code opens for 20 cycles");
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        enter_code();
        check_val("t1_submit", int'(submit), 1);
        idle(1);
        check_val("t1_submit_once", int'(submit), 0);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cnt = int'(open);
        cyc = 0;
        while (open && cyc < 40) begin
            idle(1);
            cyc++;
            if (open) cnt++;
        end
        check_val("t1_open_len", cnt, 20);
        check_val("t1_entry_en", int'(entry_en), 1);
        check_val("t1_wrong", int'(wrong_count), 0);

        $display("[TB] three wrong attempts then lockout");
        for (int s = 1; s <= 3; s++) begin
            enter_code();
            apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            check_val($sformatf("t3_wrong%0d", s), int'(wrong_count), s);
            check_val($sformatf("t3_clear%0d", s), int'(clear), 1);
        end
        check_val("t3_lockout", int'(lockout), 1);
        check_val("t3_alarm", int'(alarm), 1);
        check_val("t3_remain0", int'(lock_remain), 30);
        for (int i = 0; i < 4; i++) press(4'($urandom_range(0, 15)));
        check_val("t3_remain1", int'(lock_remain), 29);
        check_val("t3_keys_ignored", int'(digit_count), 0);
        cnt = 5;
        cyc = 0;
        while (lockout && cyc < 200) begin
            idle(1);
            cyc++;
            if (lockout) cnt++;
        end
        check_val("t3_lock_len", cnt, 120);
        check_val("t3_alarm_off", int'(alarm), 0);
        check_val("t3_wrong_clr", int'(wrong_count), 0);

        $display("[TB] entry timeout");
        press(4'd7);
        idle(39);
        check_val("t4_pre_clear", int'(clear), 0);
        check_val("t4_pre_digits", int'(digit_count), 1);
        idle(1);
        check_val("t4_clear", int'(clear), 1);
        check_val("t4_digits", int'(digit_count), 0);
        press(4'd7);
        idle(39);
        press(4'd8);
        check_val("t4_key_wins_clear", int'(clear), 0);
        check_val("t4_key_wins_digits", int'(digit_count), 2);
        idle(39);
        check_val("t4_restart_digits", int'(digit_count), 2);
        idle(1);
        check_val("t4_restart_clear", int'(clear), 1);

        $display("[TB] verdict timeout");
        enter_code();
        idle(15);
        check_val("t5_pre_clear", int'(clear), 0);
        idle(1);
        check_val("t5_clear", int'(clear), 1);
        check_val("t5_wrong", int'(wrong_count), 1);
        check_val("t5_entry_en", int'(entry_en), 1);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check_val("t5_late_open", int'(open), 0);
        check_val("t5_late_wrong", int'(wrong_count), 1);

        $display("[TB] reset mid-lockout");
        for (int s = 0; s < 2; s++) begin
            enter_code();
            apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        end
        check_val("t6_lockout", int'(lockout), 1);
        cyc = 0;
        while (lock_remain != 8'd17 && cyc < 200) begin
            idle(1);
            cyc++;
        end
        check_val("t6_reach17", int'(lock_remain), 17);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check_val("t6_lockout_off", int'(lockout), 0);
        check_val("t6_alarm_off", int'(alarm), 0);
        check_val("t6_remain", int'(lock_remain), 0);
        check_val("t6_wrong", int'(wrong_count), 0);
        check_val("t6_entry_en", int'(entry_en), 1);

        $display("[TB] random stimulus");
        for (int i = 0; i < 6000; i++) begin
            bit         kv;
            bit         vv;
            bit         vok;
            bit         rst;
            logic [3:0] code;
            int         c;
            kv  = ($urandom_range(0, 99) < 45);
            c   = int'($urandom_range(0, 99));
            if (c < 60)      code = 4'($urandom_range(0, 9));
            else if (c < 78) code = 4'hF;
            else if (c < 88) code = 4'hE;
            else             code = 4'($urandom_range(10, 13));
            vv  = ($urandom_range(0, 99) < 12);
            vok = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 999) == 0);
            apply_stimulus(rst, kv, code, vv, vok);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
